// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: one bit position per clock under a start/busy/done handshake.
// Result, zero and carry are held after completion until the next accepted start.
module seq_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [1:0] ModeLsl = 2'b00;
    localparam logic [1:0] ModeLsr = 2'b01;
    localparam logic [1:0] ModeAsr = 2'b10;
    localparam logic [1:0] ModeRor = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         mode_q, mode_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               result_upd;

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        mode_d     = mode_q;
        count_d    = count_q;
        carry_d    = carry_q;
        result_upd = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    result_d   = operand;
                    mode_d     = mode;
                    count_d    = amt;
                    carry_d    = 1'b0;
                    result_upd = 1'b1;
                    state_d    = (amt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                result_upd = 1'b1;
                unique case (mode_q)
                    ModeLsl: begin
                        carry_d  = result_q[WIDTH-1];
                        result_d = {result_q[WIDTH-2:0], 1'b0};
                    end
                    ModeLsr: begin
                        carry_d  = result_q[0];
                        result_d = {1'b0, result_q[WIDTH-1:1]};
                    end
                    // MSB replicated: the sign-extended fill
                    ModeAsr: begin
                        carry_d  = result_q[0];
                        result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                    end
                    ModeRor: begin
                        carry_d  = result_q[0];
                        result_d = {result_q[0], result_q[WIDTH-1:1]};
                    end
                    default: ;
                endcase
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        zero_d = result_upd ? (result_d == '0) : zero_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            mode_q   <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: the driver pushes hand-computed expectations on acceptance,
// and a monitor pops and compares them on every done pulse.
module tb_seq_shifter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amt;
    logic [7:0] operand;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0]  res;
        logic        z;
        logic        c;
        logic [31:0] due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt = 0;

    seq_shifter #(.WIDTH(8), .AMT_W(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .amt     (amt),
        .operand (operand),
        .result  (result),
        .zero    (zero),
        .carry   (carry),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: got result=%h with no pending request", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (result !== e.res || zero !== e.z || carry !== e.c || busy !== 1'b1
                    || cnt !== e.due) begin
                    errors++;
                    $display("FAIL done_check: got res=%h z=%b c=%b busy=%b cyc=%0d, want res=%h z=%b c=%b busy=1 cyc=%0d",
                             result, zero, carry, busy, cnt, e.res, e.z, e.c, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Waits for IDLE, issues one request and pushes its expected response; returns on a negedge
    task automatic send(input logic [1:0] m, input logic [2:0] a, input logic [7:0] op,
                        input logic [7:0] er, input logic ec);
        int   g = 0;
        exp_t e;
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
        start   = 1'b1;
        mode    = m;
        amt     = a;
        operand = op;
        @(posedge clk);
        #1;
        e.res = er;
        e.z   = (er == 8'h00);
        e.c   = ec;
        e.due = cnt + 32'(a);
        sb_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        operand = ~op;
        mode    = ~m;
        amt     = ~a;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 2'b00;
        amt     = 3'd0;
        operand = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_state", {21'd0, result, zero, carry, busy, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send(2'b10, 3'd3, 8'h96, 8'hF2, 1'b1);  // ASR sign fill
        send(2'b00, 3'd1, 8'h96, 8'h2C, 1'b1);  // LSL
        send(2'b01, 3'd7, 8'h81, 8'h01, 1'b0);  // LSR max amount
        send(2'b11, 3'd4, 8'h81, 8'h18, 1'b0);  // ROR
        send(2'b01, 3'd1, 8'h01, 8'h00, 1'b1);  // zero flag
        send(2'b00, 3'd0, 8'h5A, 8'h5A, 1'b0);  // amt=0

        // Start pulse during a 5-cycle ASR must be ignored
        send(2'b10, 3'd5, 8'hB0, 8'hFD, 1'b1);
        start   = 1'b1;
        operand = 8'hFF;
        mode    = 2'b00;
        amt     = 3'd1;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: second start lands in the first IDLE cycle after done
        send(2'b00, 3'd2, 8'h03, 8'h0C, 1'b0);
        send(2'b11, 3'd1, 8'h01, 8'h80, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        check("hold_in_idle", {22'd0, result, zero, carry}, {22'd0, 8'h80, 1'b0, 1'b1});
        check("idle_flags", {30'd0, busy, done}, 32'd0);

        // Reset in the 2nd SHIFT cycle discards the operation
        send(2'b10, 3'd3, 8'h96, 8'hF2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_op", {21'd0, result, zero, carry, busy, done}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("no_done_after_reset", {31'd0, busy}, 32'd0);

        send(2'b01, 3'd2, 8'h96, 8'h25, 1'b1);  // normal op after reset
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle 8-bit shift/rotate unit in the datapath execute stage.
- Sits directly downstream of the sign-extend unit: the operand's MSB, replicated by sign_ext, is the fill source for arithmetic right shifts.
- Shifts one bit position per clock under a start/busy/done handshake.
- Produces the result plus zero and carry flags for the flag register.

Parameters:
WIDTH, 8, operand/result width in bits
AMT_W, 3, width of shift-amount input (covers 0..WIDTH-1)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
mode  input  2  00=LSL, 01=LSR, 10=ASR, 11=ROR; captured at start
amt  input  AMT_W  shift count; captured at start
operand  input  WIDTH  value to shift; captured at start
result  output  WIDTH  shifted value; valid while done=1 and held until next accepted start
zero  output  1  result==0; updated together with result
carry  output  1  last bit shifted or rotated out; 0 if amt=0
busy  output  1  high in SHIFT and DONE
done  output  1  single-cycle pulse when result is final

Behaviour:
- Reset (async, any state, including mid-shift):
  - state=IDLE; result=0, zero=0, carry=0, busy=0, done=0; internal count=0.
  - Any operation in progress is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge T: latch operand into result register; latch mode; count=amt; carry=0.
  - Next state is SHIFT if amt!=0, else DONE.
  - start=0: hold outputs.
- SHIFT, each cycle:
  - LSL: carry=result[WIDTH-1]; result={result[WIDTH-2:0],0}.
  - LSR: carry=result[0]; result={0,result[WIDTH-1:1]}.
  - ASR: carry=result[0]; result={result[WIDTH-1],result[WIDTH-1:1]}. MSB preserved, i.e. the sign_ext fill.
  - ROR: carry=result[0]; result={result[0],result[WIDTH-1:1]}.
  - count decrements by 1 each cycle; when count==1 the next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - zero reflects the final result.
  - Next state is IDLE.
- Latency: done asserted in cycle T+1+amt. amt=0 gives done at T+1 with result=operand, carry=0.
- Input handling:
  - start in SHIFT or DONE is ignored; there is no queueing.
  - operand, mode and amt are don't-care after capture.
- Output stability:
  - result and flags hold their values in IDLE until the next accepted start.
  - result is not valid while in SHIFT.
- busy=1 in SHIFT and DONE; busy falls in the cycle after done.
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted normally.
- amt only reaches WIDTH-1. Shifts by WIDTH or more are out of scope; the decoder never issues them.

Test Plan:
- Reset mid-operation: start ASR operand=0x96 amt=3, assert rst in the 2nd SHIFT cycle -> all outputs 0 immediately, state IDLE, no done pulse; a later start behaves normally.
- ASR sign fill: operand=0x96, mode=10, amt=3 -> done at T+4, result=0xF2, carry=1, zero=0; busy high T+1..T+4.
- LSL and LSR:
  - operand=0x96, mode=00, amt=1 -> result=0x2C, carry=1.
  - operand=0x81, mode=01, amt=7 -> result=0x01, carry=0.
- Rotate and zero flag:
  - operand=0x81, mode=11, amt=4 -> result=0x18, carry=0.
  - operand=0x01, mode=01, amt=1 -> result=0x00, zero=1, carry=1.
- amt=0 and start while busy:
  - operand=0x5A, amt=0 -> done at T+1, result=0x5A, carry=0.
  - During a 5-cycle ASR, pulse start with operand=0xFF -> ignored; the original result is unaffected.
- Back-to-back: start asserted in the IDLE cycle right after done -> accepted, with correct second result and latency.
